// File: rtl/bishift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bishift_seq_ctrl
//   Command-driven sequencer for the 4-bit bidirectional shift register.
//   Takes one shift command per valid/ready handshake (direction, bit count,
//   serial pattern). It drives the register's en/dir/sin_l/sin_r for exactly
//   the requested number of cycles, then raises a one-cycle completion pulse.
//
// Parameters
//   DATA_W    max pattern bits per command (cmd_data width)
//   LEN_W     width of cmd_len; must be able to hold DATA_W
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  controller can accept a command (idle only)
//   cmd_dir    in   1 = shift in through sin_r, 0 = shift in through sin_l
//   cmd_len    in   number of shift cycles, 0 = no-op, clamped to DATA_W
//   cmd_data   in   serial pattern, bit 0 sent first
//   abort      in   terminate the current command early
//   sr_en      out  shift register enable
//   sr_dir     out  shift register direction
//   sr_sin_l   out  shift register left serial input
//   sr_sin_r   out  shift register right serial input
//   busy       out  command in progress (shifting or completing)
//   done       out  one-cycle completion pulse
//   aborted    out  qualified by done: command was cut short by abort
//   bits_sent  out  qualified by done: shift cycles issued for the command
// -----------------------------------------------------------------------------
module bishift_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              abort,
    output logic              sr_en,
    output logic              sr_dir,
    output logic              sr_sin_l,
    output logic              sr_sin_r,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  bits_sent
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    // Control state
    state_t              state_q, state_d;
    logic                dir_q, dir_d;
    logic [DATA_W-1:0]   data_q, data_d;      // remaining pattern, next bit at [0]
    logic [LEN_W-1:0]    len_q, len_d;        // clamped command length
    logic [LEN_W-1:0]    cnt_q, cnt_d;        // shift cycles completed before this one

    // Registered outputs
    logic                cmd_ready_q, cmd_ready_d;
    logic                sr_en_q, sr_en_d;
    logic                sr_sin_l_q, sr_sin_l_d;
    logic                sr_sin_r_q, sr_sin_r_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [LEN_W-1:0]    bits_sent_q, bits_sent_d;

    // Combinational helpers
    logic [LEN_W-1:0]    len_eff;
    logic [LEN_W-1:0]    cnt_inc;
    logic                accept;

    assign len_eff = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign cnt_inc = cnt_q + 1'b1;
    assign accept  = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        data_d      = data_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        sr_en_d     = 1'b0;
        sr_sin_l_d  = 1'b0;
        sr_sin_r_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        bits_sent_d = bits_sent_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (accept) begin
                    dir_d       = cmd_dir;
                    cnt_d       = '0;
                    bits_sent_d = '0;
                    aborted_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (len_eff != '0) begin
                        // Bit 0 is presented in the very first shift cycle,
                        // so it is registered out on the accept edge.
                        state_d    = ST_SHIFT;
                        len_d      = len_eff;
                        sr_en_d    = 1'b1;
                        sr_sin_r_d = cmd_dir & cmd_data[0];
                        sr_sin_l_d = ~cmd_dir & cmd_data[0];
                        data_d     = {1'b0, cmd_data[DATA_W-1:1]};
                    end else begin
                        // Zero-length command completes immediately.
                        state_d = ST_DONE;
                        len_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                cmd_ready_d = 1'b0;
                busy_d      = 1'b1;
                if (cnt_inc == len_q) begin
                    // Final bit went out this cycle; a coincident abort is
                    // moot because nothing was cut short.
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    aborted_d   = 1'b0;
                    bits_sent_d = cnt_inc;
                end else if (abort) begin
                    // The current cycle's bit was still shifted in, so it
                    // counts toward bits_sent.
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    aborted_d   = 1'b1;
                    bits_sent_d = cnt_inc;
                end else begin
                    cnt_d      = cnt_inc;
                    sr_en_d    = 1'b1;
                    sr_sin_r_d = dir_q & data_q[0];
                    sr_sin_l_d = ~dir_q & data_q[0];
                    data_d     = {1'b0, data_q[DATA_W-1:1]};
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            data_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            sr_en_q     <= 1'b0;
            sr_sin_l_q  <= 1'b0;
            sr_sin_r_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            bits_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            data_q      <= data_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            sr_en_q     <= sr_en_d;
            sr_sin_l_q  <= sr_sin_l_d;
            sr_sin_r_q  <= sr_sin_r_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            bits_sent_q <= bits_sent_d;
        end
    end

    // sr_dir keeps the last command's direction while idle; the register
    // ignores it whenever en is low.
    assign cmd_ready = cmd_ready_q;
    assign sr_en     = sr_en_q;
    assign sr_dir    = dir_q;
    assign sr_sin_l  = sr_sin_l_q;
    assign sr_sin_r  = sr_sin_r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign bits_sent = bits_sent_q;

endmodule

// File: tb/tb_bishift_seq_ctrl.sv
module tb_bishift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [3:0] cmd_len = '0;
    logic [7:0] cmd_data = '0;
    logic       abort = 1'b0;
    logic       sr_en, sr_dir, sr_sin_l, sr_sin_r;
    logic       busy, done, aborted;
    logic [3:0] bits_sent;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bishift_seq_ctrl #(.DATA_W(8), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .abort(abort),
        .sr_en(sr_en), .sr_dir(sr_dir), .sr_sin_l(sr_sin_l), .sr_sin_r(sr_sin_r),
        .busy(busy), .done(done), .aborted(aborted), .bits_sent(bits_sent)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue of per-cycle expectations ----
    localparam int K_IDLE = 0, K_SHIFT = 1, K_DONE = 2;
    typedef struct {
        int kind;
        bit sin;
        bit dir;
        bit last;
        int idx;
        int bits;
        bit ab;
        bit rstv;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    bit   live = 0;

    function automatic ent_t mk(input int kind);
        ent_t e;
        e.kind = kind; e.sin = 0; e.dir = 0; e.last = 0;
        e.idx = 0; e.bits = 0; e.ab = 0; e.rstv = 0;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            q.delete();
            cur = mk(K_IDLE);
            cur.rstv = 1;
            live = 1;
        end else if (live) begin
            if (cur.kind == K_SHIFT && !cur.last && abort) begin
                int b;
                b = cur.idx + 1;
                q.delete();
                cur = mk(K_DONE);
                cur.bits = b;
                cur.ab = 1;
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else if (cur.kind == K_IDLE && cmd_valid) begin
                int L;
                ent_t e;
                L = (int'(cmd_len) > 8) ? 8 : int'(cmd_len);
                for (int k = 0; k < L; k++) begin
                    e = mk(K_SHIFT);
                    e.sin = cmd_data[k];
                    e.dir = cmd_dir;
                    e.idx = k;
                    e.last = (k == L - 1);
                    q.push_back(e);
                end
                e = mk(K_DONE);
                e.bits = L;
                q.push_back(e);
                cur = q.pop_front();
            end else begin
                cur = mk(K_IDLE);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (live) begin
            chk("m_ready", cmd_ready, cur.kind == K_IDLE);
            chk("m_en",    sr_en,     cur.kind == K_SHIFT);
            chk("m_sin_l", sr_sin_l,  cur.kind == K_SHIFT && !cur.dir && cur.sin);
            chk("m_sin_r", sr_sin_r,  cur.kind == K_SHIFT &&  cur.dir && cur.sin);
            chk("m_busy",  busy,      cur.kind != K_IDLE);
            chk("m_done",  done,      cur.kind == K_DONE);
            if (cur.kind == K_SHIFT) chk("m_dir", sr_dir, cur.dir);
            if (cur.kind == K_DONE) begin
                chk("m_bits_sent", bits_sent, cur.bits);
                chk("m_aborted",   aborted,   cur.ab);
            end
            if (cur.rstv) begin
                chk("m_rst_bits", bits_sent, 0);
                chk("m_rst_ab",   aborted,   0);
                chk("m_rst_dir",  sr_dir,    0);
            end
        end
    end

    // ---------------- directed stimulus helpers ----------------------------
    // Called at #1 after a rising edge; returns at #1 after the accept edge.
    task automatic do_accept(input logic d, input logic [3:0] l, input logic [7:0] dt, input bit keep);
        bit ok;
        ok = 0;
        cmd_dir = d; cmd_len = l; cmd_data = dt; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: cmd_ready never high");
        end
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Watches cycles after accept (cycle 1 = first after accept edge) until done.
    task automatic observe(input int abort_at, output int en_cnt, output logic [7:0] pat_l,
                           output logic [7:0] pat_r, output int done_cyc,
                           output int bits, output int ab);
        en_cnt = 0; pat_l = '0; pat_r = '0; done_cyc = -1; bits = -1; ab = -1;
        for (int c = 1; c <= 40; c++) begin
            abort = (c == abort_at);
            @(negedge clk);
            if (sr_en === 1'b1) begin
                if (en_cnt < 8) begin
                    pat_l[en_cnt] = sr_sin_l;
                    pat_r[en_cnt] = sr_sin_r;
                end
                en_cnt++;
            end
            if (done === 1'b1) begin
                done_cyc = c; bits = int'(bits_sent); ab = int'(aborted);
            end
            @(posedge clk); #1;
            if (done_cyc > 0) break;
        end
        abort = 1'b0;
        if (done_cyc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: no done pulse within 40 cycles");
        end
    endtask

    int en_cnt, done_cyc, bits, ab, dn_cnt;
    logic [7:0] pl, pr, en_v, sl_v, sr_v, dn_v, rd_v;

    initial begin
        // Reset held two cycles
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_en",    sr_en,     0);
        chk("rst_done",  done,      0);
        chk("rst_busy",  busy,      0);
        chk("rst_bits",  bits_sent, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Right shift, 4 bits of 0x05
        do_accept(1'b1, 4'd4, 8'h05, 0);
        observe(0, en_cnt, pl, pr, done_cyc, bits, ab);
        chk("r4_en_cnt", en_cnt, 4);
        chk("r4_sin_r",  pr, 8'h05);
        chk("r4_sin_l",  pl, 8'h00);
        chk("r4_done_cyc", done_cyc, 5);
        chk("r4_bits", bits, 4);
        chk("r4_ab", ab, 0);

        // Back-to-back: second command presented while the first runs
        do_accept(1'b0, 4'd2, 8'h01, 1);
        cmd_dir = 1'b1; cmd_len = 4'd1; cmd_data = 8'h01;
        en_v = '0; sl_v = '0; sr_v = '0; dn_v = '0; rd_v = '0;
        for (int c = 1; c <= 8; c++) begin
            bit rdy;
            @(negedge clk);
            en_v[c-1] = sr_en; sl_v[c-1] = sr_sin_l; sr_v[c-1] = sr_sin_r;
            dn_v[c-1] = done;  rd_v[c-1] = cmd_ready;
            rdy = (cmd_ready === 1'b1);
            @(posedge clk); #1;
            if (rdy && cmd_valid) cmd_valid = 1'b0;
        end
        chk("b2b_en",    en_v, 8'b0001_0011);
        chk("b2b_sin_l", sl_v, 8'b0000_0001);
        chk("b2b_sin_r", sr_v, 8'b0001_0000);
        chk("b2b_done",  dn_v, 8'b0010_0100);
        chk("b2b_ready", rd_v, 8'b1100_1000);

        // Zero length
        do_accept(1'b0, 4'd0, 8'hFF, 0);
        observe(0, en_cnt, pl, pr, done_cyc, bits, ab);
        chk("z_en_cnt", en_cnt, 0);
        chk("z_done_cyc", done_cyc, 1);
        chk("z_bits", bits, 0);

        // Over length clamps to DATA_W
        do_accept(1'b0, 4'd15, 8'hA5, 0);
        observe(0, en_cnt, pl, pr, done_cyc, bits, ab);
        chk("ov_en_cnt", en_cnt, 8);
        chk("ov_sin_l", pl, 8'hA5);
        chk("ov_sin_r", pr, 8'h00);
        chk("ov_done_cyc", done_cyc, 9);
        chk("ov_bits", bits, 8);

        // Abort in 3rd shift cycle
        do_accept(1'b1, 4'd6, 8'h3C, 0);
        observe(3, en_cnt, pl, pr, done_cyc, bits, ab);
        chk("ab_en_cnt", en_cnt, 3);
        chk("ab_sin_r", pr, 8'h04);
        chk("ab_done_cyc", done_cyc, 4);
        chk("ab_aborted", ab, 1);
        chk("ab_bits", bits, 3);

        // Abort coinciding with the final shift cycle
        do_accept(1'b0, 4'd3, 8'h07, 0);
        observe(3, en_cnt, pl, pr, done_cyc, bits, ab);
        chk("abl_en_cnt", en_cnt, 3);
        chk("abl_sin_l", pl, 8'h07);
        chk("abl_aborted", ab, 0);
        chk("abl_bits", bits, 3);

        // Abort while idle is ignored
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1 abort = 1'b0;
        do_accept(1'b1, 4'd2, 8'h02, 0);
        observe(0, en_cnt, pl, pr, done_cyc, bits, ab);
        chk("ai_en_cnt", en_cnt, 2);
        chk("ai_sin_r", pr, 8'h02);
        chk("ai_aborted", ab, 0);
        chk("ai_bits", bits, 2);

        // Reset during the 2nd shift cycle
        do_accept(1'b1, 4'd5, 8'h1F, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_ready", cmd_ready, 1);
        chk("mr_en",    sr_en,     0);
        chk("mr_busy",  busy,      0);
        chk("mr_done",  done,      0);
        chk("mr_bits",  bits_sent, 0);
        dn_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done !== 1'b0) dn_cnt++;
        end
        chk("mr_no_done", dn_cnt, 0);
        @(posedge clk); #1;
        do_accept(1'b0, 4'd1, 8'h01, 0);
        observe(0, en_cnt, pl, pr, done_cyc, bits, ab);
        chk("mr_rec_en", en_cnt, 1);
        chk("mr_rec_bits", bits, 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
